// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, packet-atomic.
// Optional stall release of an idle grant is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 2170
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  input  logic                   i_tx_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_gidx;
  logic               r_last;

  logic               w_found;
  logic [PW-1:0]      w_pick;
  logic [PW-1:0]      w_cand;
  logic [NUM_REQ-1:0] w_pickOneHot;
  logic               w_gReq;
  logic               w_gLast;
  logic [7:0]         w_gData;
  logic [PW-1:0]      w_nextPtr;

  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] v);
    return (v == PW'(NUM_REQ - 1)) ? '0 : v + PW'(1);
  endfunction

  // Scan requesters starting at the round-robin pointer and take the first one asserted.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
      w_cand = wrapInc(w_cand);
    end
  end

  assign w_pickOneHot = NUM_REQ'(1) << w_pick;
  assign w_nextPtr    = wrapInc(r_gidx);

  always_comb begin
    w_gReq  = 1'b0;
    w_gLast = 1'b0;
    w_gData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == PW'(i)) begin
        w_gReq  = i_req[i];
        w_gLast = i_req_last[i];
        w_gData = i_req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CLKS + 1);

  logic [SW-1:0] r_stall;
  logic          w_timeout;

  assign w_timeout = (r_state == GRANT) && !w_gReq && (r_stall == SW'(TIMEOUT_CLKS - 1));

  // Counts only an unbroken run of granted-but-empty cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state != GRANT) || w_gReq || w_timeout) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + SW'(1);
    end
  end
`else
  if (TIMEOUT_CLKS < 1) begin : g_timeoutRange
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_last     <= 1'b0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gidx  <= w_pick;
            o_grant <= w_pickOneHot;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_gReq && !i_tx_busy) begin
            o_tx_data  <= w_gData;
            o_tx_start <= 1'b1;
            o_ack      <= o_grant;
            r_last     <= w_gLast;
            r_state    <= WAIT;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            o_grant <= '0;
            r_ptr   <= w_nextPtr;
            r_state <= IDLE;
          end
`endif
        end
        WAIT: begin
          // A non-final byte keeps the grant so the packet is never interleaved.
          if (i_tx_done) begin
            if (r_last) begin
              o_grant <= '0;
              r_ptr   <= w_nextPtr;
              r_state <= IDLE;
            end else begin
              r_state <= GRANT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic compared
// against a queue-based round-robin packet model and a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [N-1:0]     i_req;
  logic [8*N-1:0]   i_req_data;
  logic [N-1:0]     i_req_last;
  logic [N-1:0]     o_ack;
  logic [N-1:0]     o_grant;
  logic [7:0]       o_tx_data;
  logic             o_tx_start;
  logic             i_tx_busy;
  logic             i_tx_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] pData [N][16];
  bit         pLast [N][16];
  int         pLen  [N];
  int         pHead [N];
  int         modelPtr;
  int         expQ [$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(TMO)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_req_data (i_req_data),
    .i_req_last (i_req_last),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .i_tx_done  (i_tx_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic int idxOf(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_reset    = 1'b1;
    i_req      = '0;
    i_req_last = '0;
    i_req_data = '0;
    i_tx_busy  = 1'b0;
    i_tx_done  = 1'b0;
    cycle();
    cycle();
    i_reset  = 1'b0;
    modelPtr = 0;
  endtask

  task automatic clearConfig();
    for (int i = 0; i < N; i++) pLen[i] = 0;
  endtask

  task automatic addByte(input int k, input logic [7:0] d, input bit last);
    pData[k][pLen[k]] = d;
    pLast[k][pLen[k]] = last;
    pLen[k]++;
  endtask

  task automatic loadRandomConfig();
    int npk, plen;
    clearConfig();
    for (int k = 0; k < N; k++) begin
      npk = $urandom_range(0, 3);
      for (int j = 0; j < npk; j++) begin
        plen = $urandom_range(1, 3);
        for (int b = 0; b < plen; b++) addByte(k, 8'($urandom), (b == plen - 1));
      end
    end
  endtask

  // Expected transmit order: whole packets, round-robin from the model pointer.
  task automatic run_traffic(input string name);
    int cur [N];
    int p, k, found, e, gi, txCnt;
    bit txBusy, txDone, doneLoop;
    logic [N-1:0] expAck;
    for (int i = 0; i < N; i++) begin
      cur[i]   = 0;
      pHead[i] = 0;
    end
    expQ.delete();
    p = modelPtr;
    for (int guard = 0; guard < 64; guard++) begin
      found = -1;
      for (int i = 0; i < N; i++) begin
        k = (p + i) % N;
        if (found < 0 && cur[k] < pLen[k]) found = k;
      end
      if (found < 0) break;
      do begin
        expQ.push_back(found * 256 + int'(pData[found][cur[found]]));
        cur[found]++;
      end while (cur[found] < pLen[found] && !pLast[found][cur[found] - 1]);
      p = (found + 1) % N;
    end
    modelPtr = p;

    txCnt  = 0;
    txBusy = 0;
    txDone = 0;
    doneLoop = 0;
    for (int cyc = 0; cyc < 3000 && !doneLoop; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (pHead[i] < pLen[i]) begin
          i_req[i]            = 1'b1;
          i_req_data[8*i +: 8] = pData[i][pHead[i]];
          i_req_last[i]       = pLast[i][pHead[i]];
        end else begin
          i_req[i]            = 1'b0;
          i_req_data[8*i +: 8] = 8'($urandom);
          i_req_last[i]       = 1'($urandom);
        end
      end
      i_tx_busy = txBusy;
      i_tx_done = txDone;
      cycle();
      checks++;
      if (!$onehot0(o_grant) || !$onehot0(o_ack)) begin
        errors++;
        $display("[TB] FAIL %s_onehot: grant=%b ack=%b, required at most one bit each", name, o_grant, o_ack);
      end
      if (txDone) txDone = 0;
      if (o_tx_start) begin
        gi = idxOf(o_grant);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s_extra_start: got req %0d data %h, required no start", name, gi, o_tx_data);
        end else begin
          e = expQ.pop_front();
          expAck = '0;
          expAck[e / 256] = 1'b1;
          if (gi != e / 256 || o_tx_data !== 8'(e & 255) || o_ack !== expAck) begin
            errors++;
            $display("[TB] FAIL %s_start: got req %0d data %h ack %b, required req %0d data %h ack %b",
                     name, gi, o_tx_data, o_ack, e / 256, 8'(e & 255), expAck);
          end
        end
        txBusy = 1;
        txCnt  = $urandom_range(2, 6);
      end else if (txCnt > 0) begin
        txCnt--;
        if (txCnt == 0) begin
          txBusy = 0;
          txDone = 1;
        end
      end
      for (int i = 0; i < N; i++) if (o_ack[i]) pHead[i]++;
      if (expQ.size() == 0 && txCnt == 0 && !txDone && o_grant == '0) doneLoop = 1;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout: %0d bytes still pending, required 0", name, expQ.size());
    end
    i_req     = '0;
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_tx_start !== 1'b0 || o_grant !== '0) begin
        errors++;
        $display("[TB] FAIL %s_quiet: start=%b grant=%b, required 0 and 0000", name, o_tx_start, o_grant);
      end
    end
  endtask

  task automatic test_reset();
    i_reset    = 1'b1;
    i_req      = 4'b1111;
    i_req_last = 4'b1111;
    i_req_data = 32'hDEADBEEF;
    i_tx_busy  = 1'b0;
    i_tx_done  = 1'b0;
    cycle();
    cycle();
    checks++;
    if (o_grant !== '0 || o_ack !== '0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: grant=%b ack=%b start=%b data=%h, required all zero",
               o_grant, o_ack, o_tx_start, o_tx_data);
    end
    i_req   = '0;
    i_reset = 1'b0;
    modelPtr = 0;
    cycle();
    checks++;
    if (o_grant !== '0 || o_tx_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: grant=%b start=%b, required 0000 and 0", o_grant, o_tx_start);
    end
  endtask

  task automatic test_round_robin();
    doReset();
    clearConfig();
    for (int k = 0; k < N; k++) begin
      addByte(k, 8'($urandom), 1'b1);
      addByte(k, 8'($urandom), 1'b1);
    end
    run_traffic("round_robin");
  endtask

  task automatic test_multibyte();
    doReset();
    clearConfig();
    addByte(1, 8'h5C, 1'b1);
    run_traffic("mb_setup");
    clearConfig();
    addByte(2, 8'h11, 1'b0);
    addByte(2, 8'h22, 1'b0);
    addByte(2, 8'h33, 1'b1);
    addByte(0, 8'h44, 1'b1);
    run_traffic("multibyte");
  endtask

  task automatic test_busy_stall();
    doReset();
    i_req             = 4'b0010;
    i_req_data        = 32'($urandom);
    i_req_data[15:8]  = 8'hA5;
    i_req_last        = 4'b0010;
    i_tx_busy         = 1'b1;
    cycle();
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL busy_grant: grant=%b, required 0010", o_grant);
    end
    for (int i = 0; i < 50; i++) begin
      i_tx_done = (i == 20);
      cycle();
      checks++;
      if (o_tx_start !== 1'b0 || o_grant !== 4'b0010 || o_ack !== '0) begin
        errors++;
        $display("[TB] FAIL busy_hold: cycle %0d start=%b grant=%b ack=%b, required 0 0010 0000",
                 i, o_tx_start, o_grant, o_ack);
      end
    end
    i_tx_done = 1'b0;
    i_tx_busy = 1'b0;
    cycle();
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA5 || o_ack !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL busy_release: start=%b data=%h ack=%b, required 1 a5 0010",
               o_tx_start, o_tx_data, o_ack);
    end
    i_req     = '0;
    i_tx_busy = 1'b1;
    cycle();
    cycle();
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    cycle();
    i_tx_done = 1'b0;
    checks++;
    if (o_grant !== '0) begin
      errors++;
      $display("[TB] FAIL busy_finish: grant=%b, required 0000", o_grant);
    end
    modelPtr = 2;
  endtask

  task automatic test_reset_in_wait();
    doReset();
    clearConfig();
    addByte(1, 8'h3C, 1'b1);
    run_traffic("rw_setup");
    i_req             = 4'b0100;
    i_req_data[23:16] = 8'h5A;
    i_req_last        = 4'b0000;
    cycle();
    cycle();
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL rw_start: start=%b data=%h, required 1 5a", o_tx_start, o_tx_data);
    end
    i_reset   = 1'b1;
    i_req     = '0;
    i_tx_busy = 1'b1;
    cycle();
    checks++;
    if (o_grant !== '0 || o_ack !== '0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rw_outputs: grant=%b ack=%b start=%b data=%h, required all zero",
               o_grant, o_ack, o_tx_start, o_tx_data);
    end
    i_reset = 1'b0;
    cycle();
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    cycle();
    i_tx_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (o_grant !== '0 || o_ack !== '0 || o_tx_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rw_quiet: grant=%b ack=%b start=%b, required all zero", o_grant, o_ack, o_tx_start);
      end
    end
    i_req      = 4'b1001;
    i_req_last = 4'b1001;
    cycle();
    checks++;
    if (o_grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rw_ptr: grant=%b, required 0001", o_grant);
    end
    doReset();
  endtask

  task automatic test_done_in_idle();
    doReset();
    i_tx_done = 1'b1;
    cycle();
    i_tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_grant !== '0 || o_ack !== '0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL idle_done: grant=%b ack=%b start=%b data=%h, required all zero",
                 o_grant, o_ack, o_tx_start, o_tx_data);
      end
      cycle();
    end
  endtask

  task automatic test_stall();
    doReset();
    i_req             = 4'b0010;
    i_req_data        = 32'($urandom);
    i_req_data[15:8]  = 8'h77;
    i_req_last        = 4'b0000;
    cycle();
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL stall_grant: grant=%b, required 0010", o_grant);
    end
    cycle();
    checks++;
    if (o_tx_start !== 1'b1 || o_ack !== 4'b0010 || o_tx_data !== 8'h77) begin
      errors++;
      $display("[TB] FAIL stall_first: start=%b ack=%b data=%h, required 1 0010 77", o_tx_start, o_ack, o_tx_data);
    end
    i_req             = 4'b0100;
    i_req_last        = 4'b0100;
    i_req_data[23:16] = 8'h99;
    i_tx_busy         = 1'b1;
    repeat (3) cycle();
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    cycle();
    i_tx_done = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      cycle();
      checks++;
      if (o_grant !== ((i < TMO) ? 4'b0010 : 4'b0000) || o_tx_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_timeout: cycle %0d grant=%b start=%b, required %b 0",
                 i, o_grant, o_tx_start, (i < TMO) ? 4'b0010 : 4'b0000);
      end
    end
    cycle();
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL stall_next: grant=%b, required 0100", o_grant);
    end
`else
    for (int i = 0; i < 1000; i++) begin
      cycle();
      checks++;
      if (o_grant !== 4'b0010 || o_tx_start !== 1'b0 || o_ack !== '0) begin
        errors++;
        $display("[TB] FAIL stall_hold: cycle %0d grant=%b start=%b ack=%b, required 0010 0 0000",
                 i, o_grant, o_tx_start, o_ack);
      end
    end
`endif
    doReset();
  endtask

  task automatic test_random();
    doReset();
    for (int r = 0; r < 8; r++) begin
      loadRandomConfig();
      run_traffic("random");
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_multibyte();
    test_busy_stall();
    test_reset_in_wait();
    test_done_in_idle();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2170, stall limit in clocks (used only per REQ-027).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester byte-valid, level, held until acked.
REQ-006 SHALL have port i_req_data  input  8*NUM_REQ  per-requester byte; requester k on bits [8k+7:8k].
REQ-007 SHALL have port i_req_last  input  NUM_REQ  marks the byte as the final byte of a packet.
REQ-008 SHALL have port o_ack  output  NUM_REQ  one-cycle pulse: byte of requester k accepted.
REQ-009 SHALL have port o_grant  output  NUM_REQ  one-hot owner of the transmitter, zero when idle.
REQ-010 SHALL have port o_tx_data  output  8  byte to the UART transmitter, registered.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-012 SHALL have port i_tx_busy  input  1  transmitter is shifting a frame.
REQ-013 SHALL have port i_tx_done  input  1  one-cycle pulse at the end of the stop bit.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, WAIT.
REQ-015 In IDLE, when i_req != 0, SHALL pick the first asserted requester searching from r_ptr upward, wrapping modulo NUM_REQ; SHALL set o_grant one-hot and enter GRANT on the next cycle.
REQ-016 In GRANT, when i_req[g]=1 and i_tx_busy=0, SHALL on the same edge register o_tx_data=byte g, pulse o_tx_start and o_ack[g] for exactly one cycle together, latch i_req_last[g], and enter WAIT.
REQ-017 In GRANT, with i_req[g]=0 or i_tx_busy=1, SHALL hold the state and the grant and issue no start.
REQ-018 In WAIT, on i_tx_done with latched last=1, SHALL clear o_grant, set r_ptr=(g+1) mod NUM_REQ, and enter IDLE.
REQ-019 In WAIT, on i_tx_done with latched last=0, SHALL return to GRANT and keep the grant; the packet is not interleaved.
REQ-020 SHALL ignore i_tx_done in IDLE and GRANT.
REQ-021 SHALL ignore requests from non-granted requesters while a grant is held; no o_ack to them.
REQ-022 A single request with i_req_last=1 SHALL be a one-byte packet.
REQ-023 Minimum spacing SHALL be one cycle from i_tx_done to IDLE/GRANT; the next o_tx_start follows on the first cycle in GRANT with the request valid.
REQ-024 SHALL never have more than one o_grant bit or o_ack bit set at a time.

Reset
REQ-025 On i_reset=1 at a clock edge, SHALL set state=IDLE, r_ptr=0, o_grant=0, o_ack=0, o_tx_start=0, o_tx_data=0, latched last=0, and stall counter=0.
REQ-026 Reset mid-packet SHALL abandon the packet with no further start or ack; the transmitter's in-flight frame is not this block's concern.

Configuration
REQ-027 With macro UART_ARB_TIMEOUT_EN defined, SHALL count consecutive GRANT cycles with i_req[g]=0; at TIMEOUT_CLKS the block SHALL release the grant, advance r_ptr as in REQ-018, and enter IDLE; the count clears on any start.
REQ-028 Without UART_ARB_TIMEOUT_EN, the grant SHALL be held indefinitely until a last byte completes, and no counter logic SHALL be present.

Verification
REQ-029 Reset with i_req=4'b1111 -> first grant to requester 0, then 1, 2, 3, 0 as one-byte packets complete (round-robin).
REQ-030 Requester 2 sends a 3-byte packet (0x11, 0x22, 0x33 last) while requester 0 requests -> three starts for req 2 in order, then grant moves to 0.
REQ-031 i_tx_busy=1 during GRANT for 50 cycles -> no o_tx_start; start one cycle after busy falls.
REQ-032 Reset asserted in WAIT -> next cycle all outputs 0, r_ptr=0, and a later done pulse causes no action.
REQ-033 With UART_ARB_TIMEOUT_EN, TIMEOUT_CLKS=16, requester 1 drops i_req mid-packet -> grant released after 16 cycles, requester 2 granted; without the macro, the grant is held for 1000 cycles.
REQ-034 i_tx_done pulsed in IDLE with i_req=0 -> no state change, no outputs.
